// File: rtl/tap_tms_driver.sv
// tap_tms_driver: JTAG initiator. Expands reset/idle/shift-IR/shift-DR
// commands into TMS/TDI bit streams. Tracks the target TAP state in lock-step.
// Captures TDO during shift bits.
module tap_tms_driver (
    input  logic        clk,
    input  logic        TRST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    input  logic        tdo,
    output logic        tms,
    output logic        tdi,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [3:0]  tap_state
);
    typedef enum logic [3:0] {
        TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3,
        SHDR = 4'd4, EX1DR = 4'd5, PAUDR = 4'd6, EX2DR = 4'd7,
        UPDDR = 4'd8, SELIR = 4'd9, CAPIR = 4'd10, SHIR = 4'd11,
        EX1IR = 4'd12, PAUIR = 4'd13, EX2IR = 4'd14, UPDIR = 4'd15
    } tap_t;

    typedef enum logic [1:0] {
        OP_RESET = 2'd0, OP_IDLE = 2'd1, OP_SHIFT_IR = 2'd2, OP_SHIFT_DR = 2'd3
    } op_t;

    // Per-bit description of the command stream: TMS value, and whether the
    // bit is a data-shift bit (with its index into cmd_data / rsp_data).
    typedef struct packed {
        logic       tms;
        logic       shift;
        logic [4:0] idx;
    } bit_t;

    tap_t        tap_reg, tap_next;
    logic        tms_reg, tms_next;
    logic        tdi_reg, tdi_next;
    logic        ready_reg, ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [5:0]  n_reg, n_next;
    op_t         op_reg, op_next;
    logic        pre_reg, pre_next;
    logic [5:0]  len_reg, len_next;
    logic [31:0] data_reg, data_next;

    op_t         acc_op;
    logic        acc_pre;
    logic [5:0]  acc_slen;
    logic [5:0]  acc_len;
    logic [5:0]  acc_n;
    bit_t        acc_bit, cur_bit, nxt_bit;

    // Bit j (1-based) of a command stream. An optional leading TLR->RTI bit
    // shifts the remaining pattern by one position.
    function automatic bit_t bit_at(input op_t op, input logic pre,
                                    input logic [5:0] len, input logic [5:0] j);
        bit_t       b;
        logic [5:0] jj;
        logic [5:0] h;
        b  = '0;
        jj = j - {5'd0, pre};
        h  = (op == OP_SHIFT_IR) ? 6'd4 : 6'd3;
        if (pre && j == 6'd1) begin
            b.tms = 1'b0;
        end else begin
            case (op)
                OP_RESET: b.tms = (jj <= 6'd5);
                OP_IDLE:  b.tms = 1'b0;
                default: begin
                    if (jj <= h) begin
                        b.tms = (op == OP_SHIFT_IR) ? (jj <= 6'd2) : (jj == 6'd1);
                    end else if (jj <= h + len) begin
                        b.shift = 1'b1;
                        b.idx   = 5'(jj - h - 6'd1);
                        b.tms   = (jj == h + len);
                    end else begin
                        b.tms = (jj == h + len + 6'd1);
                    end
                end
            endcase
        end
        return b;
    endfunction

    // Full IEEE 1149.1 transition table driven by the TMS currently presented.
    always_comb begin
        tap_next = tap_reg;
        case (tap_reg)
            TLR:   tap_next = tms_reg ? TLR   : RTI;
            RTI:   tap_next = tms_reg ? SELDR : RTI;
            SELDR: tap_next = tms_reg ? SELIR : CAPDR;
            CAPDR: tap_next = tms_reg ? EX1DR : SHDR;
            SHDR:  tap_next = tms_reg ? EX1DR : SHDR;
            EX1DR: tap_next = tms_reg ? UPDDR : PAUDR;
            PAUDR: tap_next = tms_reg ? EX2DR : PAUDR;
            EX2DR: tap_next = tms_reg ? UPDDR : SHDR;
            UPDDR: tap_next = tms_reg ? SELDR : RTI;
            SELIR: tap_next = tms_reg ? TLR   : CAPIR;
            CAPIR: tap_next = tms_reg ? EX1IR : SHIR;
            SHIR:  tap_next = tms_reg ? EX1IR : SHIR;
            EX1IR: tap_next = tms_reg ? UPDIR : PAUIR;
            PAUIR: tap_next = tms_reg ? EX2IR : PAUIR;
            EX2IR: tap_next = tms_reg ? UPDIR : SHIR;
            UPDIR: tap_next = tms_reg ? SELDR : RTI;
            default: tap_next = TLR;
        endcase
    end

    // Command sequencer: accept, emit one bit per cycle, capture TDO, complete.
    always_comb begin
        tms_next       = tms_reg;
        tdi_next       = tdi_reg;
        ready_next     = ready_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = rsp_data_reg;
        cnt_next       = cnt_reg;
        n_next         = n_reg;
        op_next        = op_reg;
        pre_next       = pre_reg;
        len_next       = len_reg;
        data_next      = data_reg;

        acc_op   = op_t'(cmd_op);
        acc_pre  = (acc_op != OP_RESET) && (tap_reg == TLR);
        acc_slen = (cmd_len == 6'd0) ? 6'd1 : ((cmd_len > 6'd32) ? 6'd32 : cmd_len);
        acc_len  = (acc_op == OP_IDLE) ? cmd_len : acc_slen;
        case (acc_op)
            OP_RESET:    acc_n = 6'd6;
            OP_IDLE:     acc_n = (cmd_len + {5'd0, acc_pre} == 6'd0) ? 6'd1
                                 : cmd_len + {5'd0, acc_pre};
            OP_SHIFT_IR: acc_n = acc_slen + 6'd6 + {5'd0, acc_pre};
            default:     acc_n = acc_slen + 6'd5 + {5'd0, acc_pre};
        endcase
        acc_bit = bit_at(acc_op, acc_pre, acc_len, 6'd1);
        cur_bit = bit_at(op_reg, pre_reg, len_reg, cnt_reg);
        nxt_bit = bit_at(op_reg, pre_reg, len_reg, cnt_reg + 6'd1);

        if (ready_reg) begin
            // Parked: hold TLR with TMS=1, anywhere else idle with TMS=0.
            tms_next = (tap_next == TLR);
            tdi_next = 1'b0;
            if (cmd_valid) begin
                ready_next    = 1'b0;
                rsp_data_next = '0;
                op_next       = acc_op;
                pre_next      = acc_pre;
                len_next      = acc_len;
                n_next        = acc_n;
                data_next     = cmd_data;
                cnt_next      = 6'd1;
                tms_next      = acc_bit.tms;
                tdi_next      = acc_bit.shift & cmd_data[acc_bit.idx];
            end
        end else begin
            if (cur_bit.shift) begin
                rsp_data_next[cur_bit.idx] = tdo;
            end
            if (cnt_reg == n_reg) begin
                rsp_valid_next = 1'b1;
                ready_next     = 1'b1;
                tms_next       = (tap_next == TLR);
                tdi_next       = 1'b0;
            end else begin
                cnt_next = cnt_reg + 6'd1;
                tms_next = nxt_bit.tms;
                tdi_next = nxt_bit.shift & data_reg[nxt_bit.idx];
            end
        end
    end

    // State registers; TRST drops any command in flight.
    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            tap_reg       <= TLR;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            cnt_reg       <= '0;
            n_reg         <= '0;
            op_reg        <= OP_RESET;
            pre_reg       <= 1'b0;
            len_reg       <= '0;
            data_reg      <= '0;
        end else begin
            tap_reg       <= tap_next;
            tms_reg       <= tms_next;
            tdi_reg       <= tdi_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            cnt_reg       <= cnt_next;
            n_reg         <= n_next;
            op_reg        <= op_next;
            pre_reg       <= pre_next;
            len_reg       <= len_next;
            data_reg      <= data_next;
        end
    end

    assign tms       = tms_reg;
    assign tdi       = tdi_reg;
    assign cmd_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign tap_state = tap_reg;
endmodule

// File: doc/tap_tms_driver.md
# tap_tms_driver

JTAG initiator that drives TMS/TDI into an IEEE 1149.1 TAP controller and captures TDO. It accepts high-level commands (reset, idle, shift IR, shift DR) over a valid/ready handshake and expands each into the exact TMS sequence. It tracks the target's 16-state TAP FSM in lock-step, so it always knows where the controller is. It sits on the host side of the test-access bus and shares `clk` and `TRST` with the target TAP.

## Interface
- No parameters. Shift length is fixed at max 32, with data LSB first.
- `clk` in 1: single clock. The target samples `tms`/`tdi` on the same rising edge.
- `TRST` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle, can accept.
- `cmd_op` in 2: 0=RESET, 1=IDLE, 2=SHIFT_IR, 3=SHIFT_DR.
- `cmd_len` in 6: bit count for shifts, or cycle count for IDLE.
- `cmd_data` in 32: TDI payload, bit 0 shifted first.
- `tdo` in 1: serial data from the target.
- `tms` out 1: registered test-mode select.
- `tdi` out 1: registered serial data to the target.
- `rsp_valid` out 1: one-cycle pulse at command completion.
- `rsp_data` out 32: captured TDO, right-justified, with unused upper bits 0.
- `tap_state` out 4: tracked target state, encoded 0=TLR, 1=RTI, 2=SelDR, 3=CapDR, 4=ShDR, 5=Ex1DR, 6=PauDR, 7=Ex2DR, 8=UpdDR, 9=SelIR, 10=CapIR, 11=ShIR, 12=Ex1IR, 13=PauIR, 14=Ex2IR, 15=UpdIR.

## Operation
- **Reset values:** `tms`=1, `tdi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `tap_state`=TLR, internal counters 0.
- **State tracking:** on every rising edge, `tap_state` advances by the full 1149.1 transition table using the `tms` value present before the edge.
- **Handshake:** a command is accepted on an edge with `cmd_valid`&&`cmd_ready`. `cmd_ready` drops on that edge and rises on the edge that raises `rsp_valid`. Inputs are ignored while `cmd_ready`=0.
- **Between commands:** `tms` holds 1 if `tap_state`=TLR, otherwise 0.
- **Entry prefix:** if a non-RESET command is accepted while `tap_state`=TLR, one `tms`=0 bit (TLR→RTI) is emitted first.
- **RESET:** emits `tms` 1,1,1,1,1,0 and ends in RTI. This works from any tracked state.
- **IDLE:** emits `tms`=0 for `cmd_len` cycles. With `cmd_len`=0, `rsp_valid` pulses on the edge after accept.
- **SHIFT_DR from RTI:** `tms` 1,0,0 (→ShDR), then `len` shift bits with `tms`=0 except the last bit (`tms`=1, →Ex1DR), then 1,0 (→UpdDR→RTI). That is len+5 bits in total.
- **SHIFT_IR from RTI:** `tms` 1,1,0,0, then the shift bits as above, then 1,0. That is len+6 bits in total.
- **Shift length:** `cmd_len` 0 is treated as 1, and values above 32 are treated as 32.
- **TDI:** bit i of latched `cmd_data` is driven on `tdi` during shift bit i. `tdi`=0 outside shift bits.
- **TDO capture:** `tdo` is sampled on the edge that consumes shift bit i and stored to `rsp_data[i]`. `rsp_data` is cleared at accept.
- **Completion:** commands always end with `tap_state`=RTI. `rsp_data` holds its value until the next accept.
- **TRST mid-command:** all outputs return to reset values immediately. The command is dropped and no `rsp_valid` is issued.

## Timing
- Outputs are registered. The first command bit appears on `tms` in the cycle after the accept edge E0.
- Bit k (k=1..N) is consumed by the target at edge Ek. `rsp_valid` is set at edge EN and stays high for exactly one cycle.
- **N values:** RESET 6; IDLE len; SHIFT_DR len+5; SHIFT_IR len+6. Add 1 to non-RESET commands when starting from TLR.
- **Back-to-back:** a command offered in the `rsp_valid` cycle is accepted at that cycle's closing edge, so there is no dead cycle.
- **Count mismatch:** `tap_state` must equal the target's state every cycle. Any mismatch is a failure.

## Test plan
- **Shift DR after reset:** release TRST, then SHIFT_DR len=8 data=0xA5 with the tdo model returning 0x3C LSB first. Expect `tms` = 0,1,0,0,0,0,0,0,0,0,0,1,1,0 (14 bits), `tdi` shift bits = 1,0,1,0,0,1,0,1, `rsp_data`=0x0000003C at E14, and `tap_state`=RTI.
- **Shift IR from RTI:** SHIFT_IR len=4 data=0x6. Expect `tms` = 1,1,0,0,0,0,0,1,1,0, `rsp_valid` at E10, and state passing ShIR for exactly 4 consumed bits.
- **Reset from a shift state:** RESET issued from RTI, and separately with the target forced into PauDR via a bench-driven TRST-free path. Expect 6 bits of 1,1,1,1,1,0 and `tap_state`=RTI at E6.
- **Edge values:** IDLE len=0 gives `rsp_valid` at E1 with `tms` staying 0. SHIFT_DR len=0 behaves as len=1 (6 bits). len=40 behaves as 32 with a full 32-bit `rsp_data`.
- **Back-to-back:** SHIFT_DR len=32 followed immediately by SHIFT_DR len=1. Expect the second accept in the `rsp_valid` cycle, then the second `tms` stream starting 1,0,0 on the next cycle.
- **Abort:** assert TRST at shift bit 3 of a SHIFT_DR len=16. Expect immediate `tms`=1, `cmd_ready`=1, `tap_state`=TLR, `rsp_data`=0, and no `rsp_valid`.
